rle_decompressor: RTL

RLE_DECOMPRESSOR -- requirements
Module: rle_decompressor

---
 rtl/decomp_pkg.sv | 23 ++
 rtl/rle_run_counter.sv | 55 +++++
 rtl/rle_decompressor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/decomp_pkg.sv
// Shared definitions for the RLE image decompressor.
//   - state_e : decompressor FSM states
//   - PixOff / PixOnDefault : pixel byte values for clear / set pixels
//   - ValueBit, RunMsb, RunLsb, RunW : field layout of a compressed word
//       bit 15 = pixel value, bits 14:0 = run length
package decomp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StExpand,
        StDone
    } state_e;

    localparam logic [7:0] PixOff       = 8'h00;
    localparam logic [7:0] PixOnDefault = 8'hFF;

    localparam int unsigned ValueBit = 15;
    localparam int unsigned RunMsb   = 14;
    localparam int unsigned RunLsb   = 0;
    localparam int unsigned RunW     = RunMsb - RunLsb + 1;

endpackage

// File: rtl/rle_run_counter.sv
// Run and pixel counters for the RLE decompressor.
// Ports:
//   clk, RST     - clock, synchronous active-high reset
//   clearCount   - restart pixel count for a new image
//   loadRun      - latch runIn as the writes left in the current word
//   runIn        - run length of the accepted word
//   step         - one pixel written this cycle
//   lastPixel    - current write ends the word or the image
//   imageLast    - current write is pixel IMG_PIXELS-1
//   truncating   - current write ends the image while the word still has pixels left
module rle_run_counter
    import decomp_pkg::*;
#(
    parameter int unsigned IMG_PIXELS = 784
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            clearCount,
    input  logic            loadRun,
    input  logic [RunW-1:0] runIn,
    input  logic            step,
    output logic            lastPixel,
    output logic            imageLast,
    output logic            truncating
);

    localparam logic [15:0]     LastIdx = 16'(IMG_PIXELS - 1);
    localparam logic [RunW-1:0] RunOne  = RunW'(1);

    logic [RunW-1:0] runLeft;
    logic [15:0]     pixCount;

    always_ff @(posedge clk) begin
        if (RST) begin
            runLeft  <= '0;
            pixCount <= '0;
        end else begin
            if (clearCount) begin
                pixCount <= '0;
            end else if (step) begin
                pixCount <= pixCount + 16'd1;
            end
            if (loadRun) begin
                runLeft <= runIn;
            end else if (step) begin
                runLeft <= runLeft - RunOne;
            end
        end
    end

    assign imageLast  = (pixCount == LastIdx);
    assign lastPixel  = (runLeft == RunOne) || imageLast;
    assign truncating = imageLast && (runLeft != RunOne);

endmodule

// File: rtl/rle_decompressor.sv
// RLE image decompressor: expands 16-bit run words into one pixel byte per cycle
// written to RAM starting at IMAGE_BASE, until IMG_PIXELS pixels are written.
// Optional feature: define RLE_OVERFLOW_CHECK_EN to enable the sticky err flag
// (truncated run, or a non-empty word offered after the image is complete).
// Ports:
//   clk, RST    - clock, synchronous active-high reset
//   load, cnn   - load session active; cnn=1 means parameter load (block idle)
//   Din         - compressed word {value, run[14:0]}, qualified by din_valid
//   din_ready   - word accepted this cycle when din_valid=1
//   ramAddress, ramDataIn, writeSignal - RAM byte write port
//   done        - full image written
//   err         - sticky overflow flag (0 unless RLE_OVERFLOW_CHECK_EN)
module rle_decompressor
    import decomp_pkg::*;
#(
    parameter int unsigned IMG_PIXELS = 784,
    parameter logic [15:0] IMAGE_BASE = 16'h0000,
    parameter logic [7:0]  PIX_ONE    = PixOnDefault
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        load,
    input  logic        cnn,
    input  logic [15:0] Din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [15:0] ramAddress,
    output logic [7:0]  ramDataIn,
    output logic        writeSignal,
    output logic        done,
    output logic        err
);

    state_e          state;
    logic [RunW-1:0] dinRun;
    logic            dinValue;
    logic            startImage;
    logic            acceptRun;
    logic            stepPix;
    logic            lastPixel;
    logic            imageLast;
    logic            truncating;

    assign dinRun     = Din[RunMsb:RunLsb];
    assign dinValue   = Din[ValueBit];
    assign startImage = (state == StIdle) && load && !cnn;
    assign acceptRun  = (state == StFetch) && load && din_valid && (dinRun != '0);
    // Every EXPAND cycle with load held is a write.
    assign stepPix    = (state == StExpand) && load;

    rle_run_counter #(
        .IMG_PIXELS(IMG_PIXELS)
    ) uRunCounter (
        .clk       (clk),
        .RST       (RST),
        .clearCount(startImage),
        .loadRun   (acceptRun),
        .runIn     (dinRun),
        .step      (stepPix),
        .lastPixel (lastPixel),
        .imageLast (imageLast),
        .truncating(truncating)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            state       <= StIdle;
            ramAddress  <= IMAGE_BASE;
            ramDataIn   <= PixOff;
            writeSignal <= 1'b0;
            din_ready   <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (startImage) begin
                        state      <= StFetch;
                        ramAddress <= IMAGE_BASE;
                        din_ready  <= 1'b1;
                    end
                end
                StFetch: begin
                    if (!load) begin
                        state     <= StIdle;
                        din_ready <= 1'b0;
                    end else if (acceptRun) begin
                        // First pixel goes out the cycle after acceptance.
                        state       <= StExpand;
                        din_ready   <= 1'b0;
                        writeSignal <= 1'b1;
                        ramDataIn   <= dinValue ? PIX_ONE : PixOff;
                    end
                end
                StExpand: begin
                    if (!load) begin
                        state       <= StIdle;
                        writeSignal <= 1'b0;
                    end else begin
                        ramAddress <= ramAddress + 16'd1;
                        if (imageLast) begin
                            state       <= StDone;
                            writeSignal <= 1'b0;
                            done        <= 1'b1;
                        end else if (lastPixel) begin
                            state       <= StFetch;
                            writeSignal <= 1'b0;
                            din_ready   <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (!load) begin
                        state <= StIdle;
                        done  <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef RLE_OVERFLOW_CHECK_EN
    logic errQ;

    always_ff @(posedge clk) begin
        if (RST || startImage) begin
            errQ <= 1'b0;
        end else if ((stepPix && truncating) ||
                     ((state == StDone) && load && din_valid && (dinRun != '0))) begin
            errQ <= 1'b1;
        end
    end

    assign err = errQ;
`else
    logic unusedTrunc;
    assign unusedTrunc = truncating;
    assign err         = 1'b0;
`endif

endmodule
